// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt controller slice.
// Fixed priority: IR0 is the highest priority level and IR7 the lowest.
package pic_pkg;

    localparam int PIC_NUM_IR = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } pic_state_t;

    // Index of the lowest set bit, or 8 when no bit is set.
    function automatic logic [3:0] pic_lowest_set(input logic [7:0] vec);
        logic [3:0] lvl;
        lvl = 4'd8;
        for (int i = PIC_NUM_IR - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lvl = 4'(i);
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Combinational fixed-priority resolver for the fully nested mode.
// A request is pending only if it outranks everything already in service.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [7:0] in_service_register,
    output logic [3:0] req_lvl,
    output logic [3:0] isr_lvl,
    output logic       pending
);

    logic [7:0] eligible_s;

    // Lowest unmasked request against lowest in-service level.
    always_comb begin
        eligible_s = interrupt_request_register & ~interrupt_mask;
        req_lvl    = pic_lowest_set(eligible_s);
        isr_lvl    = pic_lowest_set(in_service_register);
        pending    = (eligible_s != 8'h00) && (req_lvl < isr_lvl);
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: two-pulse INTA handshake, ISR upkeep,
// EOI handling and vector drive for the consumer side of the IRR.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter bit INTA_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       inta_n,
    output logic       int_out,
    output logic       freeze,
    output logic [7:0] clear_IRR,
    output logic [7:0] in_service_register,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    logic [3:0] req_lvl_s;
    logic [3:0] isr_lvl_s;
    logic       pending_s;
    logic       grant_s;
    logic       ia_s;
    logic       ia_d_r;
    logic       fall_s;
    logic       rise_s;
    pic_state_t state_r;
    logic [2:0] win_r;
    logic       spurious_r;
    logic [7:0] isr_r;
    logic [7:0] eoi_clr_s;
    logic [7:0] isr_set_s;
    logic [7:0] isr_auto_clr_s;
    logic       int_out_r;
    logic       freeze_r;
    logic       data_out_enable_r;
    logic [7:0] clear_irr_r;
    logic [7:0] data_out_r;

    priority_resolver u_resolver (
        .interrupt_request_register (interrupt_request_register),
        .interrupt_mask             (interrupt_mask),
        .in_service_register        (isr_r),
        .req_lvl                    (req_lvl_s),
        .isr_lvl                    (isr_lvl_s),
        .pending                    (pending_s)
    );

    generate
        if (INTA_SYNC) begin : g_sync
            logic sync1_r;
            logic sync2_r;
            // Two-flop synchronizer; idles high like the bus line.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_r <= 1'b1;
                    sync2_r <= 1'b1;
                end else begin
                    sync1_r <= inta_n;
                    sync2_r <= sync1_r;
                end
            end
            assign ia_s = sync2_r;
        end else begin : g_nosync
            assign ia_s = inta_n;
        end
    endgenerate

    // Previous acknowledge level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ia_d_r <= 1'b1;
        end else begin
            ia_d_r <= ia_s;
        end
    end

    assign fall_s  = ia_d_r & ~ia_s;
    assign rise_s  = ~ia_d_r & ia_s;
    assign grant_s = pending_s & ~req_lvl_s[3];

    // ISR set/clear masks; EOI and auto-EOI clear, the ACK1 set overrides both.
    always_comb begin
        eoi_clr_s      = 8'h00;
        isr_set_s      = 8'h00;
        isr_auto_clr_s = 8'h00;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_clr_s = 8'd1 << eoi_level;
            end else if (isr_lvl_s != 4'd8) begin
                eoi_clr_s = 8'd1 << isr_lvl_s[2:0];
            end else begin
                eoi_clr_s = 8'h00;
            end
        end else begin
            eoi_clr_s = 8'h00;
        end
        if ((state_r == IDLE) && fall_s && grant_s) begin
            isr_set_s = 8'd1 << req_lvl_s[2:0];
        end else begin
            isr_set_s = 8'h00;
        end
        if ((state_r == ACK2) && rise_s && auto_eoi && !spurious_r) begin
            isr_auto_clr_s = 8'd1 << win_r;
        end else begin
            isr_auto_clr_s = 8'h00;
        end
    end

    // Handshake FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= IDLE;
            win_r             <= 3'd0;
            spurious_r        <= 1'b0;
            isr_r             <= 8'h00;
            int_out_r         <= 1'b0;
            freeze_r          <= 1'b0;
            data_out_enable_r <= 1'b0;
            clear_irr_r       <= 8'h00;
            data_out_r        <= 8'h00;
        end else begin
            clear_irr_r <= 8'h00;
            isr_r       <= (isr_r & ~(eoi_clr_s | isr_auto_clr_s)) | isr_set_s;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r   <= ACK1;
                        int_out_r <= 1'b0;
                        freeze_r  <= 1'b1;
                        if (grant_s) begin
                            win_r       <= req_lvl_s[2:0];
                            spurious_r  <= 1'b0;
                            clear_irr_r <= 8'd1 << req_lvl_s[2:0];
                        end else begin
                            // Nothing to grant: answer with the IR7 vector.
                            win_r      <= 3'd7;
                            spurious_r <= 1'b1;
                        end
                    end else begin
                        int_out_r <= pending_s;
                    end
                end
                ACK1: begin
                    if (rise_s) begin
                        state_r <= WAIT2;
                    end else begin
                        state_r <= ACK1;
                    end
                end
                WAIT2: begin
                    if (fall_s) begin
                        state_r           <= ACK2;
                        data_out_enable_r <= 1'b1;
                        data_out_r        <= {vector_base, win_r};
                    end else begin
                        state_r <= WAIT2;
                    end
                end
                ACK2: begin
                    if (rise_s) begin
                        state_r           <= IDLE;
                        data_out_enable_r <= 1'b0;
                        data_out_r        <= 8'h00;
                        freeze_r          <= 1'b0;
                    end else begin
                        data_out_r <= {vector_base, win_r};
                    end
                end
                default: begin
                    state_r           <= IDLE;
                    data_out_enable_r <= 1'b0;
                    data_out_r        <= 8'h00;
                    freeze_r          <= 1'b0;
                    int_out_r         <= 1'b0;
                end
            endcase
        end
    end

    assign int_out             = int_out_r;
    assign freeze              = freeze_r;
    assign clear_IRR           = clear_irr_r;
    assign in_service_register = isr_r;
    assign data_out            = data_out_r;
    assign data_out_enable     = data_out_enable_r;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a bench-side behavioural model of the acknowledge sequencer.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [7:0] imr = 8'h00;
    logic [4:0] vb = 5'd0;
    logic       aeoi = 1'b0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       inta_n = 1'b1;
    logic       int_out;
    logic       freeze;
    logic [7:0] clear_irr;
    logic [7:0] isr;
    logic [7:0] data_out;
    logic       data_out_enable;

    logic [7:0] m_isr = 8'h00;
    int         n_checks = 0;
    int         n_pass = 0;

    interrupt_ack_sequencer #(.INTA_SYNC(1'b1)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .interrupt_request_register (irr),
        .interrupt_mask             (imr),
        .vector_base                (vb),
        .auto_eoi                   (aeoi),
        .eoi_valid                  (eoi_valid),
        .eoi_specific               (eoi_specific),
        .eoi_level                  (eoi_level),
        .inta_n                     (inta_n),
        .int_out                    (int_out),
        .freeze                     (freeze),
        .clear_IRR                  (clear_irr),
        .in_service_register        (isr),
        .data_out                   (data_out),
        .data_out_enable            (data_out_enable)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    function automatic bit m_pending();
        logic [7:0] elig;
        elig = irr & ~imr;
        return (elig != 8'h00) && (lowest(elig) < lowest(m_isr));
    endfunction

    function automatic logic [7:0] eoi_apply(input logic [7:0] cur, input bit spec, input logic [2:0] lvl);
        logic [7:0] r;
        r = cur;
        if (spec) r[lvl] = 1'b0;
        else if (cur != 8'h00) r[lowest(cur)] = 1'b0;
        return r;
    endfunction

    task automatic do_eoi(input string tag, input bit spec, input logic [2:0] lvl);
        eoi_valid    = 1'b1;
        eoi_specific = spec;
        eoi_level    = lvl;
        step(1);
        eoi_valid = 1'b0;
        m_isr = eoi_apply(m_isr, spec, lvl);
        check_value({tag, "_isr"}, isr, m_isr);
    endtask

    // Full two-pulse acknowledge; eoi_mode 1/2 fires a non-specific/specific
    // EOI on the same clock as the first-pulse detection.
    task automatic do_ack(input string tag, input int eoi_mode, input logic [2:0] eoi_lvl);
        bit         p;
        int         w;
        logic [7:0] exp_clr;
        logic [2:0] w3;
        p = m_pending();
        w = p ? lowest(irr & ~imr) : 7;
        w3 = 3'(w);
        exp_clr = p ? (8'd1 << w3) : 8'h00;
        inta_n = 1'b0;
        if (eoi_mode != 0) begin
            step(2);
            eoi_valid    = 1'b1;
            eoi_specific = (eoi_mode == 2);
            eoi_level    = eoi_lvl;
            step(1);
            eoi_valid = 1'b0;
            m_isr = eoi_apply(m_isr, eoi_mode == 2, eoi_lvl);
        end else begin
            step(3);
        end
        if (p) m_isr[w3] = 1'b1;
        check_value({tag, "_clr"}, clear_irr, exp_clr);
        check_value({tag, "_isr1"}, isr, m_isr);
        check_value({tag, "_int0"}, int_out, 1'b0);
        check_value({tag, "_doe0"}, data_out_enable, 1'b0);
        if (p) check_value({tag, "_frz1"}, freeze, 1'b1);
        step(1);
        check_value({tag, "_clr_pulse"}, clear_irr, 8'h00);
        if (p) irr[w3] = 1'b0;
        step($urandom_range(0, 2));
        inta_n = 1'b1;
        step(3);
        check_value({tag, "_doe_mid"}, data_out_enable, 1'b0);
        check_value({tag, "_data_mid"}, data_out, 8'h00);
        if (p) check_value({tag, "_frz_mid"}, freeze, 1'b1);
        step($urandom_range(1, 3));
        inta_n = 1'b0;
        step(3);
        check_value({tag, "_doe1"}, data_out_enable, 1'b1);
        check_value({tag, "_vec"}, data_out, {vb, w3});
        step($urandom_range(0, 2));
        inta_n = 1'b1;
        step(3);
        if (aeoi && p) m_isr[w3] = 1'b0;
        check_value({tag, "_doe_end"}, data_out_enable, 1'b0);
        check_value({tag, "_data_end"}, data_out, 8'h00);
        check_value({tag, "_frz_end"}, freeze, 1'b0);
        check_value({tag, "_isr_end"}, isr, m_isr);
        step(1);
    endtask

    initial begin
        step(2);
        check_value("rst_int", int_out, 1'b0);
        check_value("rst_frz", freeze, 1'b0);
        check_value("rst_clr", clear_irr, 8'h00);
        check_value("rst_isr", isr, 8'h00);
        check_value("rst_data", data_out, 8'h00);
        check_value("rst_doe", data_out_enable, 1'b0);
        rst = 1'b1;
        step(1);

        // Basic acknowledge of IR3 with vector base 0x08.
        vb = 5'b01000;
        irr = 8'h08;
        step(1);
        check_value("basic_int", int_out, 1'b1);
        do_ack("basic", 0, 3'd0);
        check_value("basic_vec_abs", {vb, 3'd3}, 8'h43);
        check_value("basic_isr_abs", isr, 8'h08);
        do_eoi("basic_eoi", 1'b0, 3'd0);

        // Masked IR1 leaves IR7 as winner.
        irr = 8'h82;
        imr = 8'h02;
        step(1);
        do_ack("mask", 0, 3'd0);
        check_value("mask_isr_abs", isr, 8'h80);
        do_eoi("mask_eoi", 1'b1, 3'd7);
        imr = 8'h00;

        // Fully nested behaviour.
        irr = 8'h04;
        step(1);
        do_ack("nest_a", 0, 3'd0);
        irr = 8'h10;
        step(2);
        check_value("nest_low_blocked", int_out, 1'b0);
        irr = 8'h01;
        step(1);
        check_value("nest_high_int", int_out, 1'b1);
        do_ack("nest_b", 0, 3'd0);
        check_value("nest_isr05", isr, 8'h05);
        do_eoi("nest_nseoi", 1'b0, 3'd0);
        check_value("nest_isr04", isr, 8'h04);
        do_eoi("nest_seoi", 1'b1, 3'd2);

        // Auto EOI.
        aeoi = 1'b1;
        irr = 8'h20;
        step(1);
        do_ack("aeoi", 0, 3'd0);
        check_value("aeoi_isr0", isr, 8'h00);
        aeoi = 1'b0;

        // Spurious acknowledge after request withdrawn.
        irr = 8'h02;
        step(1);
        check_value("spur_int1", int_out, 1'b1);
        irr = 8'h00;
        step(1);
        check_value("spur_int0", int_out, 1'b0);
        do_ack("spur", 0, 3'd0);

        // Reset in the middle of the second pulse.
        irr = 8'h08;
        step(1);
        inta_n = 1'b0;
        step(4);
        inta_n = 1'b1;
        step(4);
        inta_n = 1'b0;
        step(3);
        check_value("rstmid_doe1", data_out_enable, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_value("rstmid_doe", data_out_enable, 1'b0);
        check_value("rstmid_frz", freeze, 1'b0);
        check_value("rstmid_isr", isr, 8'h00);
        check_value("rstmid_data", data_out, 8'h00);
        m_isr = 8'h00;
        inta_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        check_value("rstmid_int", int_out, 1'b1);
        do_ack("rst_fresh", 0, 3'd0);
        do_eoi("rst_fresh_eoi", 1'b0, 3'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int r;
            irr  = 8'($urandom);
            imr  = 8'($urandom) & 8'($urandom);
            vb   = 5'($urandom);
            aeoi = 1'($urandom_range(0, 1));
            step(1);
            check_value("rnd_int", int_out, m_pending());
            r = $urandom_range(0, 9);
            if (r < 7) begin
                do_ack("rnd_ack", (r < 2) ? r + 1 : 0, 3'($urandom_range(0, 7)));
            end else begin
                do_eoi("rnd_eoi", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Consumer side of the interrupt request register: resolves priority among pending, unmasked requests and raises the interrupt line to the CPU. It runs the two-pulse INTA handshake (8086 mode) and maintains the in-service register (ISR). It drives the vector onto the data bus and feeds `clear_IRR` and `freeze` back to the request register. It also applies EOI commands from the control logic.

## Interface
Parameters:
- `INTA_SYNC`, default 1: 1 = two-flop synchronizer on `inta_n`; 0 = `inta_n` is already synchronous to `clk`.

Ports:
- `clk` in 1: system clock. Already decided.
- `rst` in 1: reset, asynchronous, active-low. Already decided.
- `interrupt_request_register` in 8: current IRR contents.
- `interrupt_mask` in 8: IMR; 1 = line masked.
- `vector_base` in 5: ICW2 bits T7–T3.
- `auto_eoi` in 1: 1 = clear the ISR bit automatically at the end of the second INTA.
- `eoi_valid` in 1: one-cycle EOI command strobe.
- `eoi_specific` in 1: 1 = specific EOI, 0 = non-specific EOI.
- `eoi_level` in 3: target level for a specific EOI.
- `inta_n` in 1: CPU interrupt acknowledge, active-low.
- `int_out` out 1: interrupt request to the CPU.
- `freeze` out 1: holds the IRR during acknowledge.
- `clear_IRR` out 8: one-cycle clear pulse to the IRR.
- `in_service_register` out 8: ISR.
- `data_out` out 8: vector byte.
- `data_out_enable` out 1: data bus drive enable.

## Operation
- Priority is fixed: IR0 is highest, IR7 is lowest.
  - `eligible = IRR & ~IMR`.
  - `req_lvl` is the lowest set index of `eligible`.
  - `isr_lvl` is the lowest set index of the ISR, or 8 if the ISR is empty.
  - `pending` = `eligible != 0` and `req_lvl < isr_lvl` (fully nested mode).
- `ia` = `inta_n` after the optional synchronizer. A falling edge (`fall`) is `ia_d=1, ia=0`; a rising edge (`rise`) is `ia_d=0, ia=1`.
- State machine, encoding in the package:
  - IDLE: `int_out <= pending`. A `fall` goes to ACK1 and executes the ACK1 entry action.
  - ACK1 entry action, on the cycle `fall` is seen:
    - Latch `win = req_lvl`.
    - If `pending` was 0, latch `win = 7` with a `spurious` flag set: no ISR set, no clear.
    - Otherwise set `ISR[win]`, pulse `clear_IRR[win]` for one cycle, drop `int_out`, assert `freeze`.
  - ACK1: waits for `rise` -> WAIT2.
  - WAIT2: `fall` -> ACK2.
  - ACK2: `data_out = {vector_base, win}`, `data_out_enable = 1`.
    - On `rise`: drop `data_out_enable` and `freeze`, and go to IDLE.
    - If `auto_eoi=1` and not spurious, clear `ISR[win]` on the same `rise` cycle.
- A `fall` while IDLE with `int_out=0` is still treated as the ACK1 entry: spurious, vector IR7.
- EOI (`eoi_valid`), accepted in any state:
  - Non-specific clears the ISR bit at `isr_lvl` (no-op if the ISR is empty).
  - Specific clears `ISR[eoi_level]`.
  - If an EOI and the ACK1 set hit the same cycle: the EOI clear applies first, then the set. The set wins on the same bit.
- `data_out` = 0 whenever `data_out_enable` = 0.

## Timing
- Reset values:
  - State = IDLE.
  - `int_out`, `freeze`, `data_out_enable` = 0.
  - `clear_IRR`, `in_service_register`, `data_out` = 0.
  - Synchronizer flops and `ia_d` = 1.
- `int_out` is registered: it rises 1 clk after `pending` becomes 1.
  - If `pending` falls in IDLE (request withdrawn, masked, or EOI), `int_out` falls 1 clk later.
- `inta_n` edge to detection: 3 clk with `INTA_SYNC=1`, 1 clk with `INTA_SYNC=0`.
- On the detection clk edge, the following are all registered and visible on the next cycle:
  - `freeze`=1, `int_out`=0, `clear_IRR[win]`=1 (for exactly 1 cycle), `ISR[win]`=1.
- `data_out_enable` rises on the clk the second `fall` is detected and falls on the clk the second `rise` is detected.
- `freeze` stays continuously high from the first `fall` detection to the second `rise` detection.
- Reset asserted mid-handshake: everything returns to reset values immediately. A subsequent `inta_n` low is treated as a new first pulse.

## Structure
- Shared package `pic_pkg`:
  - Constant `PIC_NUM_IR = 8`.
  - State typedef {IDLE, ACK1, WAIT2, ACK2}.
  - Function `pic_lowest_set(8b) -> 4b`, which returns 8 when the input is empty. The IRR block and the control logic reuse it.
- Sub-module `priority_resolver`: combinational. Takes IRR, IMR and ISR; produces `req_lvl`, `isr_lvl` and `pending`.
- The sequencer holds the FSM, synchronizer, ISR, EOI logic and vector mux.

## Test plan
- `vector_base=5'b01000`, IRR=8'h08, IMR=0, two INTA pulses:
  - `int_out` rises.
  - After the 1st pulse: `clear_IRR`=8'h08 for one cycle, ISR=8'h08, `freeze`=1.
  - 2nd pulse: `data_out`=8'h43.
  - `freeze` drops after the 2nd rise.
- IRR=8'h82, IMR=8'h02, acknowledge: winner is IR7, vector low bits = 3'b111, ISR=8'h80.
- Nesting:
  - ISR=8'h04 after one acknowledge, then IRR=8'h10: `int_out` stays 0.
  - IRR=8'h01: `int_out`=1.
  - Non-specific EOI with ISR=8'h05: ISR=8'h04.
- `auto_eoi=1`: ISR bit set after the 1st pulse and cleared on the 2nd `rise`; ISR=0 at the end.
- Spurious: IRR drops to 0 after `int_out`=1 but before INTA.
  - `int_out` falls 1 clk later.
  - An INTA sequence still returns `vector_base`+7, ISR unchanged, `clear_IRR`=0.
- Reset during ACK2: `data_out_enable`, `freeze`, ISR all 0 at once. The next INTA pair behaves as a fresh acknowledge.
